// File: rtl/filter_pkg.sv
// Shared constants for the streaming kernel filter: default geometry, fixed-point
// binary points and the result width helper.
package filter_pkg;

    localparam int unsigned DEF_HEIGHT_NB = 3;
    localparam int unsigned DEF_WIDTH_NB  = 3;
    localparam int unsigned DEF_IMG_WIDTH = 16;
    localparam int unsigned DEF_KER_WIDTH = 8;

    localparam int unsigned IMG_FIXED = DEF_IMG_WIDTH / 4;
    localparam int unsigned KER_FIXED = DEF_KER_WIDTH / 2;
    localparam int unsigned OUT_FIXED = IMG_FIXED + KER_FIXED;

    function automatic int unsigned rw_of(int unsigned img_w, int unsigned ker_w);
        return img_w + ker_w;
    endfunction

    localparam int unsigned RW = rw_of(DEF_IMG_WIDTH, DEF_KER_WIDTH);

endpackage

// File: rtl/filter_row.sv
// One kernel row: a WIDTH_NB-tap shifting pixel window and a registered signed MAC
// against the supplied coefficients, accumulated modulo 2^(IMG_WIDTH+KER_WIDTH).
module filter_row
    import filter_pkg::*;
#(
    parameter int unsigned WIDTH_NB  = DEF_WIDTH_NB,
    parameter int unsigned IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int unsigned KER_WIDTH = DEF_KER_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    shift_i,
    input  logic [IMG_WIDTH-1:0]                    pix_i,
    input  logic [WIDTH_NB*KER_WIDTH-1:0]           ker_i,
    input  logic                                    load_i,
    output logic [rw_of(IMG_WIDTH, KER_WIDTH)-1:0]  result_o
);

    localparam int unsigned RowW = rw_of(IMG_WIDTH, KER_WIDTH);

    logic [WIDTH_NB-1:0][IMG_WIDTH-1:0] win_q, win_d;
    logic [RowW-1:0]                    acc_d, res_q;
    logic signed [RowW-1:0]             pix_ext, ker_ext;

    always_comb begin
        win_d = win_q;
        if (shift_i) begin
            win_d[0] = pix_i;
            for (int t = 1; t < WIDTH_NB; t++) begin
                win_d[t] = win_q[t-1];
            end
        end
    end

    // Both operands sign-extended to the result width, so every product is exact
    // and the running sum simply wraps.
    always_comb begin
        acc_d   = '0;
        pix_ext = '0;
        ker_ext = '0;
        for (int t = 0; t < WIDTH_NB; t++) begin
            pix_ext = RowW'($signed(win_q[t]));
            ker_ext = RowW'($signed(ker_i[t*KER_WIDTH +: KER_WIDTH]));
            acc_d   = acc_d + RowW'(pix_ext * ker_ext);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
            res_q <= '0;
        end else begin
            win_q <= win_d;
            if (load_i) begin
                res_q <= acc_d;
            end
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/filter.sv
// Streaming 2-D kernel filter: serial one-hot-token coefficient loading, one
// filter_row per kernel row, and a two-stage valid pipeline.
module filter
    import filter_pkg::*;
#(
    parameter int unsigned HEIGHT_NB = DEF_HEIGHT_NB,
    parameter int unsigned WIDTH_NB  = DEF_WIDTH_NB,
    parameter int unsigned IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int unsigned KER_WIDTH = DEF_KER_WIDTH
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [KER_WIDTH-1:0]                             cfg_ker,
    input  logic                                             cfg_val,
    input  logic [HEIGHT_NB*IMG_WIDTH-1:0]                   up_img,
    input  logic                                             up_val,
    output logic [HEIGHT_NB*rw_of(IMG_WIDTH, KER_WIDTH)-1:0] result,
    output logic                                             result_val
);

    localparam int unsigned NumK = HEIGHT_NB * WIDTH_NB;
    localparam int unsigned TopW = rw_of(IMG_WIDTH, KER_WIDTH);

    logic [NumK-1:0]                 token_q, token_d;
    logic [NumK-1:0][KER_WIDTH-1:0]  ker_q, ker_d;
    logic                            val_q;
    logic                            result_val_q;

    always_comb begin
        token_d = token_q;
        ker_d   = ker_q;
        if (cfg_val) begin
            for (int k = 0; k < NumK; k++) begin
                if (token_q[k]) begin
                    ker_d[k] = cfg_ker;
                end
            end
            token_d = {token_q[NumK-2:0], token_q[NumK-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            token_q      <= NumK'(1);
            ker_q        <= '0;
            val_q        <= 1'b0;
            result_val_q <= 1'b0;
        end else begin
            token_q      <= token_d;
            ker_q        <= ker_d;
            val_q        <= up_val;
            result_val_q <= val_q;
        end
    end

    assign result_val = result_val_q;

    // Slot k = r*WIDTH_NB + t feeds tap t of row r.
    for (genvar r = 0; r < HEIGHT_NB; r++) begin : g_row
        filter_row #(
            .WIDTH_NB  (WIDTH_NB),
            .IMG_WIDTH (IMG_WIDTH),
            .KER_WIDTH (KER_WIDTH)
        ) u_row (
            .clk      (clk),
            .rst      (rst),
            .shift_i  (up_val),
            .pix_i    (up_img[r*IMG_WIDTH +: IMG_WIDTH]),
            .ker_i    (ker_q[r*WIDTH_NB +: WIDTH_NB]),
            .load_i   (val_q),
            .result_o (result[r*TopW +: TopW])
        );
    end

endmodule

// File: tb/tb_filter.sv
// Scoreboard bench for filter: a high-level window/kernel model predicts each result
// at issue time; a negedge monitor pops and compares whenever result_val is seen.
module tb_filter;
    import filter_pkg::*;

    localparam int H  = 3;
    localparam int W  = 3;
    localparam int IW = 16;
    localparam int KW = 8;
    localparam int RWD = IW + KW;

    logic              clk = 1'b0;
    logic              rst;
    logic [KW-1:0]     cfg_ker;
    logic              cfg_val;
    logic [H*IW-1:0]   up_img;
    logic              up_val;
    logic [H*RWD-1:0]  result;
    logic              result_val;

    filter #(
        .HEIGHT_NB (H),
        .WIDTH_NB  (W),
        .IMG_WIDTH (IW),
        .KER_WIDTH (KW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_ker    (cfg_ker),
        .cfg_val    (cfg_val),
        .up_img     (up_img),
        .up_val     (up_val),
        .result     (result),
        .result_val (result_val)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: coefficient table, next slot index, per-row tap history.
    int kmod [H*W];
    int tok;
    int wmod [H][W];
    logic [H*RWD-1:0] exp_q [$];
    logic [H*RWD-1:0] obs_q [$];
    logic [H*RWD-1:0] last_res;

    function automatic logic [H*RWD-1:0] model_result();
        logic [H*RWD-1:0] e;
        longint acc;
        logic [63:0] a;
        e = '0;
        for (int r = 0; r < H; r++) begin
            acc = 0;
            for (int t = 0; t < W; t++) acc += longint'(kmod[r*W+t]) * longint'(wmod[r][t]);
            a = acc;
            e[r*RWD +: RWD] = a[RWD-1:0];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < H*W; k++) kmod[k] = 0;
        for (int r = 0; r < H; r++) for (int t = 0; t < W; t++) wmod[r][t] = 0;
        tok = 0;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [H*RWD-1:0] act,
                       input logic [H*RWD-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock of stimulus; called at posedge+1.
    task automatic step(input logic cv, input logic [KW-1:0] ck, input logic uv,
                        input logic [H*IW-1:0] img);
        logic signed [KW-1:0] ks;
        logic signed [IW-1:0] ps;
        cfg_val = cv;
        cfg_ker = ck;
        up_val  = uv;
        up_img  = img;
        if (cv) begin
            ks = ck;
            kmod[tok] = ks;
            tok = (tok + 1) % (H*W);
        end
        if (uv) begin
            for (int r = 0; r < H; r++) begin
                for (int t = W-1; t > 0; t--) wmod[r][t] = wmod[r][t-1];
                ps = img[r*IW +: IW];
                wmod[r][0] = ps;
            end
            exp_q.push_back(model_result());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        cfg_val = 1'b0;
        up_val = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [H*IW-1:0] ramp(input int n);
        logic [H*IW-1:0] v;
        v[0*IW +: IW] = IW'(8 * n);
        v[1*IW +: IW] = IW'(16 * n);
        v[2*IW +: IW] = IW'(24 * n);
        return v;
    endfunction

    // Monitor: compare on valid, otherwise require the output to hold.
    initial begin
        last_res = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_res = '0;
            end else if (result_val) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got result %h with result_val=1, required none",
                             result);
                end else begin
                    chk("result", result, exp_q.pop_front());
                end
                obs_q.push_back(result);
                last_res = result;
            end else begin
                chk("hold", result, last_res);
            end
        end
    end

    initial begin
        logic [H*IW-1:0] img;
        logic [H*RWD-1:0] o;
        cfg_ker = '0;
        cfg_val = 1'b0;
        up_img  = '0;
        up_val  = 1'b0;
        rst     = 1'b1;
        model_reset();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, '0);
        chk("reset_valid", H*RWD'(result_val), '0);
        chk("reset_token", H*RWD'(dut.token_q), H*RWD'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Interrupted config stream.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h08, 1'b0, '0);
        step(1'b0, 8'h55, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h08, 1'b0, '0);
        for (int k = 0; k < H*W; k++) chk("cfg_coef", H*RWD'(dut.ker_q[k]), H*RWD'(8'h08));
        chk("cfg_token_wrap", H*RWD'(dut.token_q), H*RWD'(1));

        step(1'b1, 8'h10, 1'b0, '0);
        chk("cfg10_slot0", H*RWD'(dut.ker_q[0]), H*RWD'(8'h10));
        chk("cfg10_slot1", H*RWD'(dut.ker_q[1]), H*RWD'(8'h08));
        chk("cfg10_token", H*RWD'(dut.token_q), H*RWD'(2));
        for (int i = 0; i < H*W; i++) step(1'b1, 8'h08, 1'b0, '0);

        // Ramp n=1..10, then restart at n=1.
        obs_q.delete();
        for (int n = 1; n <= 10; n++) step(1'b0, '0, 1'b1, ramp(n));
        step(1'b0, '0, 1'b1, ramp(1));
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        n_vec++;
        if (obs_q.size() != 11) begin
            n_err++;
            $display("FAIL ramp_count: got %0d outputs, required 11", obs_q.size());
        end else begin
            o = obs_q[0];
            chk("ramp_n1_row0", H*RWD'(o[0 +: RWD]), H*RWD'((1 << OUT_FIXED) / 4));
            chk("ramp_n1_row1", H*RWD'(o[RWD +: RWD]), H*RWD'((1 << OUT_FIXED) / 2));
            o = obs_q[2];
            chk("ramp_n3_row2", H*RWD'(o[2*RWD +: RWD]), H*RWD'(9 * (1 << OUT_FIXED) / 2));
            o = obs_q[9];
            chk("ramp_n10_row2", H*RWD'(o[2*RWD +: RWD]), H*RWD'(81 * (1 << OUT_FIXED) / 4));
            chk("ramp_n10_row1", H*RWD'(o[RWD +: RWD]), H*RWD'(27 * (1 << OUT_FIXED) / 2));
            o = obs_q[10];
            chk("restart_row2", H*RWD'(o[2*RWD +: RWD]), H*RWD'(15 * (1 << OUT_FIXED)));
        end

        // Gapped beats.
        step(1'b0, '0, 1'b1, ramp(2));
        step(1'b0, '0, 1'b0, ramp(7));
        step(1'b0, '0, 1'b0, ramp(9));
        step(1'b0, '0, 1'b1, ramp(3));
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b1, ramp(4));

        // Random traffic with a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset(3);
                chk("midreset_token", H*RWD'(dut.token_q), H*RWD'(1));
                chk("midreset_valid", H*RWD'(result_val), '0);
            end
            img[31:0]  = $urandom();
            img[47:32] = 16'($urandom());
            step($urandom_range(0, 3) == 0, 8'($urandom()), $urandom_range(0, 2) != 0, img);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0);
        chk("drain_empty", H*RWD'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
